// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand request and result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   modport master (
      output in_valid, a, b, cin, op_sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );
   modport slave (
      input  in_valid, a, b, cin, op_sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract computed one nibble per clock through a shared 4-bit Brent-Kung adder.
module brent_kung_cin (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [4:0] out
);
   logic [3:0] g, p, c;
   logic       g10, p10, g32, p32, g30, p30;
   assign g   = a & b;
   assign p   = a ^ b;
   assign g10 = g[1] | (p[1] & g[0]);
   assign p10 = p[1] & p[0];
   assign g32 = g[3] | (p[3] & g[2]);
   assign p32 = p[3] & p[2];
   assign g30 = g32 | (p32 & g10);
   assign p30 = p32 & p10;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g10 | (p10 & cin);
   assign c[3] = g[2] | (p[2] & c[2]);
   assign out  = {g30 | (p30 & cin), p ^ c};
endmodule

module nibble_serial_adder #(parameter int WIDTH = 16) (
   input logic                 clk,
   input logic                 rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] opa, opb, sum_r;
   logic             carry, cout_r, ovf_r;
   logic [4:0]       out;
   brent_kung_cin u_bk (.a(opa[4*idx+:4]), .b(opb[4*idx+:4]), .cin(carry), .out(out));
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign bus.overflow  = ovf_r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         opa    <= '0;
         opb    <= '0;
         carry  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            opa   <= bus.a;
            opb   <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub | bus.cin;
            idx   <= '0;
            sum_r <= '0;
            state <= RUN;
         end
      end else if (state == RUN) begin
         sum_r[4*idx+:4] <= out[3:0];
         carry           <= out[4];
         idx             <= idx == LAST ? '0 : idx + IW'(1);
         if (idx == LAST) begin
            state  <= DONE;
            cout_r <= out[4];
            // out[3] is the freshly written sign bit of the result
            ovf_r  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (out[3] != opa[WIDTH-1]);
         end
      end else if (bus.out_ready) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: random and directed operations checked every cycle against a behavioural model.
module tb_nibble_serial_adder;
   localparam int W = 16;
   localparam int NIB = W / 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   nibble_serial_adder_if #(.WIDTH(W)) bif ();
   nibble_serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: idle / busy for NIB edges / holding a result
   bit m_idle = 1'b1, m_valid = 1'b0;
   int m_cnt = 0;
   logic [W-1:0] e_sum = '0, p_sum;
   logic e_cout = 1'b0, e_ovf = 1'b0, p_cout, p_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1; m_valid = 1'b0; m_cnt = 0;
         e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
      end else if (m_idle) begin
         if (bif.in_valid) begin
            int sa, sb, res;
            logic [W:0] full;
            sa = int'($signed(bif.a));
            sb = int'($signed(bif.b));
            if (bif.op_sub) begin
               p_sum  = bif.a - bif.b;
               p_cout = bif.a >= bif.b;
               res    = sa - sb;
            end else begin
               full   = {1'b0, bif.a} + {1'b0, bif.b} + {{W{1'b0}}, bif.cin};
               p_sum  = full[W-1:0];
               p_cout = full[W];
               res    = sa + sb + int'(bif.cin);
            end
            p_ovf  = res > 32767 || res < -32768;
            m_idle = 1'b0;
            m_cnt  = NIB;
         end
      end else if (!m_valid) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_valid = 1'b1; e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
         end
      end else if (bif.out_ready) begin
         m_valid = 1'b0; m_idle = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", W'(bif.in_ready), W'(m_idle));
      chk("out_valid", W'(bif.out_valid), W'(m_valid));
      if (m_idle || m_valid) begin
         chk("sum", bif.sum, e_sum);
         chk("cout", W'(bif.cout), W'(e_cout));
         chk("overflow", W'(bif.overflow), W'(e_ovf));
      end
   end

   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s,
                     input int hold, input bit lit, input logic [W-1:0] es, input logic ec, input logic eo);
      int lat;
      bit got;
      @(negedge clk);
      bif.a = x; bif.b = y; bif.cin = c; bif.op_sub = s; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bif.out_valid) begin
            got = 1'b1;
            bif.in_valid = 1'b0;
            bif.out_ready = hold == 0;
         end else begin
            bif.in_valid = 1'($urandom);
            bif.a = W'($urandom); bif.b = W'($urandom);
            bif.cin = 1'($urandom); bif.op_sub = 1'($urandom);
            @(posedge clk);
            lat++;
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL timeout: no out_valid within 20 cycles");
         bif.in_valid = 1'b0;
         return;
      end
      if (lit) begin
         chk("lit_latency", W'(lat), W'(NIB));
         chk("lit_sum", bif.sum, es);
         chk("lit_cout", W'(bif.cout), W'(ec));
         chk("lit_ovf", W'(bif.overflow), W'(eo));
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bif.in_valid = 1'($urandom);
      end
      if (hold > 0) begin
         @(negedge clk);
         bif.in_valid = 1'b0; bif.out_ready = 1'b1;
      end
      @(negedge clk);
      chk("idle_after_release", W'(bif.in_ready), W'(1));
   endtask

   initial begin
      bif.in_valid = 1'b0; bif.out_ready = 1'b1;
      bif.a = '0; bif.b = '0; bif.cin = 1'b0; bif.op_sub = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b0);
      op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h8000, 1'b0, 1'b1);
      op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1, 16'h5556, 1'b0, 1'b0);
      op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1, 16'h7FFF, 1'b1, 1'b1);
      op(16'h0003, 16'h0005, 1'b0, 1'b1, 10, 1, 16'hFFFE, 1'b0, 1'b0);
      // abandon an operation two nibbles in
      @(negedge clk);
      bif.a = 16'hFFFF; bif.b = 16'hFFFF; bif.cin = 1'b1; bif.op_sub = 1'b0; bif.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk) bif.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", W'(bif.out_valid), W'(0));
      chk("rst_in_ready", W'(bif.in_ready), W'(1));
      chk("rst_sum", bif.sum, 16'h0000);
      chk("rst_cout", W'(bif.cout), W'(0));
      @(negedge clk) rst_n = 1'b1;
      op(16'h00F0, 16'h0010, 1'b0, 1'b0, 0, 1, 16'h0100, 1'b0, 1'b0);
      for (int n = 0; n < 40; n++)
         op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0);
      op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b1);
      op(16'h0000, 16'h8000, 1'b0, 1'b1, 2, 1, 16'h8000, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle W-bit adder/subtractor that time-multiplexes one instance of the team's 4-bit Brent-Kung carry-in adder (brent_kung_cin).
- Processes one nibble per clock, LSB first, and registers the inter-nibble carry.
- Sits directly upstream of brent_kung_cin: it slices operands, feeds A/B/Cin, and consumes out[4:0].
- Uses valid/ready handshakes on both sides, for area-constrained datapaths where a full-width adder is too large.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NIB, WIDTH/4 (derived, localparam): number of nibble iterations.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add only; ignored when op_sub=1)
- op_sub  input  1  1 = A − B (two's complement), 0 = A + B + cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0.
  - Nibble index = 0; carry register = 0; operand registers = 0.
  - Reset mid-operation abandons the operation silently; no result is ever presented for it.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, on in_valid & in_ready at edge E0:
  - Capture a into opa.
  - Capture b into opb if op_sub=0, else ~b.
  - Carry register = op_sub ? 1 : cin.
  - idx=0; clear sum; go to RUN.
- RUN:
  - Adder inputs are opa[4*idx+:4], opb[4*idx+:4] and the carry register.
  - At each edge, write out[3:0] into sum[4*idx+:4] and out[4] into the carry register, then increment idx.
  - On the edge where idx==NIB-1: go to DONE, set cout = out[4], and compute overflow.
  - Overflow = (opa[W-1]==opb[W-1]) && (new sum[W-1] != opa[W-1]).
  - Nibbles are written at edges E1..E_NIB; out_valid is first high in the cycle after E_NIB.
  - Latency from accept edge to out_valid high is NIB cycles (4 for WIDTH=16).
- DONE:
  - sum/cout/overflow are held stable while out_valid=1 and out_ready=0 (indefinite backpressure).
  - On out_valid & out_ready: go to IDLE, out_valid falls next cycle. sum/cout/overflow keep their last value until the next accept.
  - No same-cycle accept of a new operation in DONE (in_ready=0). Throughput is one op per NIB+2 cycles with out_ready tied high.
- Input handling:
  - in_valid while not in IDLE is ignored; a/b/cin/op_sub are sampled only on the accept edge.
  - Input changes during RUN have no effect.
- Arithmetic:
  - Modulo 2^WIDTH; carry chains across nibble boundaries strictly through the carry register.
  - Carry-in for nibble 0 is the captured cin (add) or 1 (subtract).
- No combinational path from in_valid to in_ready or from out_ready to out_valid; all outputs are registered or decoded from state.

Test Plan:
- WIDTH=16, add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0; out_valid exactly 4 cycles after accept edge.
- Add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1; add 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0.
- Sub 0x8000 − 0x0001 (op_sub=1, cin=1 supplied) -> sum=0x7FFF, cout=1, overflow=1; sub 0x0003 − 0x0005 -> sum=0xFFFE, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum/cout/overflow stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, in_ready=1.
- Change a/b during RUN, and pulse in_valid during RUN/DONE -> result matches operands captured at accept; no second operation is started.
- Assert rst_n=0 asynchronously after 2 nibbles of an op -> outputs immediately at reset values, no out_valid. The next op, 0x00F0 + 0x0010, yields 0x0100 correctly (carry register cleared).
